sort_seq: RTL and testbench
===========================

// Module: sort_seq
// PURPOSE
//  Clocked, handshaked successor of the combinational SR-latch bit sorter for oversampled data.
//  Sorts an N=SAMPLES*OSF bit vector so all ones are packed at the LSB end (thermometer code).
//  Also reports the ones count. Uses odd-even transposition: one phase per clock.
//  Sits between the oversampling capture stage and the decimation/decoding logic.
// PARAMETERS
//  SAMPLES  2  samples per word
//  OSF      8  oversampling factor per sample
//  N        SAMPLES*OSF (localparam)  vector width; N>=2 required
//  CW       $clog2(N+1) (localparam)  count width
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   data_in valid
//  in_ready   out  1   block can accept (high only in IDLE)
//  data_in    in   N   raw oversampled bits
//  out_valid  out  1   result valid
//  out_ready  in   1   downstream accepts result
//  data_out   out  N   sorted vector, ones at bit 0 upward; 0 when out_valid=0
//  count_out  out  CW  number of ones; 0 when out_valid=0
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; working register=0; out_valid=0; data_out=0; count_out=0; phase counter=0.
//   - in_ready=1 once rst_n is released.
//   - Reset mid-SORT or mid-DONE aborts the operation; the result is discarded.
//  FSM IDLE/SORT/DONE; in_ready = (state==IDLE).
//  IDLE:
//   - On in_valid&in_ready: load data_in into work reg, phase=0, go SORT. Analogue of precharge.
//  SORT: each edge performs one phase on work reg w.
//   - Even phase (phase[0]=0): pairs (0,1),(2,3),...
//   - Odd phase: pairs (1,2),(3,4),...
//   - Compare-swap for pair (i,i+1): if w[i]==0 && w[i+1]==1 then w[i]<=1, w[i+1]<=0.
//   - Unpaired edge bits hold. phase increments; a swap flag records any swap in the phase.
//  Termination: see CONFIGURATION. On the terminating edge, go DONE and register outputs.
//   - out_valid=1; data_out=w (sorted); count_out=popcount(w).
//   - count_out equals the index of the first 0 in w, or N if w is all ones.
//  DONE:
//   - Outputs stay stable while out_ready=0.
//   - On out_ready=1: out_valid, data_out and count_out all go 0 next edge; go IDLE.
//   - in_valid is ignored in DONE: no same-cycle accept. Next input is accepted no earlier
//     than the cycle after returning to IDLE.
//  Latency:
//   - Acceptance edge e0; phases run on edges e1..ek; out_valid is high from ek.
//   - Throughput is one vector per k+2 cycles at best.
//  Widths: count_out is zero-extended to CW; N=16 gives CW=5, so count 16 is 5'd16.
//  Input data_in is sampled only at acceptance; changes afterwards have no effect.
// CONFIGURATION
//  SORT_EARLY_EXIT_EN defined:
//   - k = first phase p>=2 where phases p-1 and p both had no swap, capped at N.
//   - Minimum k=2, e.g. for already-sorted input.
//  SORT_EARLY_EXIT_EN undefined:
//   - k=N always; deterministic latency; swap flag logic is not built.
// TESTING (N=16 unless noted)
//  T1 data_in=16'h8000 -> data_out=16'h0001, count_out=5'd1.
//     Without EN, out_valid exactly 16 cycles after acceptance.
//  T2 data_in=16'hA5A5 -> data_out=16'h00FF, count_out=5'd8.
//  T3 data_in=16'hFFFF -> data_out=16'hFFFF, count_out=5'd16.
//     With EN, out_valid 2 cycles after acceptance.
//  T4 data_in=16'h0000 -> data_out=0, count_out=0. Still a valid result with out_valid=1.
//     With EN, latency 2.
//  T5 out_ready=0 for 5 cycles in DONE -> data_out/count_out/out_valid stable, in_ready=0.
//     Then out_ready=1 -> all outputs 0 next cycle, in_ready=1.
//  T6 rst_n pulsed low during SORT of 16'h0F0F -> out_valid never rises, outputs 0, in_ready=1.
//     Next vector 16'h0003 then sorts correctly: 16'h0003, count 2.

Source files
------------

// File: rtl/sort_seq.sv
// Handshaked odd-even transposition bit sorter: packs ones toward bit 0 and reports their count.
// Optional SORT_EARLY_EXIT_EN stops once two consecutive phases perform no swap.
module sort_seq #(
    parameter int unsigned SAMPLES = 2,
    parameter int unsigned OSF     = 8,
    localparam int unsigned N      = SAMPLES * OSF,
    localparam int unsigned CW     = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  data_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  data_out,
    output logic [CW-1:0] count_out
);

    typedef enum logic [1:0] {StIdle, StSort, StDone} state_e;

    state_e        state_q;
    logic [N-1:0]  w_q;
    logic [CW-1:0] phase_q;
    logic [N-1:0]  w_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          last_phase;
`ifdef SORT_EARLY_EXIT_EN
    logic          swapped;
    logic          prev_clean_q;
`endif

    assign in_ready = (state_q == StIdle);

    // Pairs within a phase are disjoint, so every compare-swap reads the pre-phase vector.
    always_comb begin
        w_nxt = w_q;
`ifdef SORT_EARLY_EXIT_EN
        swapped = 1'b0;
`endif
        for (int i = 0; i < int'(N) - 1; i++) begin
            if ((i % 2) == int'(phase_q[0])) begin
                if (!w_q[i] && w_q[i+1]) begin
                    w_nxt[i]   = 1'b1;
                    w_nxt[i+1] = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
                    swapped    = 1'b1;
`endif
                end
            end
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < int'(N); i++) begin
            cnt_nxt = cnt_nxt + CW'(w_nxt[i]);
        end
    end

    // phase_q holds the zero-based index of the phase being performed on this edge.
`ifdef SORT_EARLY_EXIT_EN
    assign last_phase = (phase_q == CW'(N - 1)) ||
                        ((phase_q != '0) && !swapped && prev_clean_q);
`else
    assign last_phase = (phase_q == CW'(N - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            w_q          <= '0;
            phase_q      <= '0;
            out_valid    <= 1'b0;
            data_out     <= '0;
            count_out    <= '0;
`ifdef SORT_EARLY_EXIT_EN
            prev_clean_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        w_q          <= data_in;
                        phase_q      <= '0;
                        state_q      <= StSort;
`ifdef SORT_EARLY_EXIT_EN
                        prev_clean_q <= 1'b0;
`endif
                    end
                end
                StSort: begin
                    w_q          <= w_nxt;
                    phase_q      <= phase_q + CW'(1);
`ifdef SORT_EARLY_EXIT_EN
                    prev_clean_q <= !swapped;
`endif
                    if (last_phase) begin
                        state_q   <= StDone;
                        out_valid <= 1'b1;
                        data_out  <= w_nxt;
                        count_out <= cnt_nxt;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                        data_out  <= '0;
                        count_out <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_seq.sv
// Scoreboard bench for sort_seq: stimulus pushes model results, a negedge monitor pops and checks.
// Compile with SORT_EARLY_EXIT_EN defined to check the early-exit latency rules instead.
module tb_sort_seq;

    localparam int N  = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  data_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  data_out;
    logic [CW-1:0] count_out;

    sort_seq #(.SAMPLES(2), .OSF(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .count_out (count_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  data;
        logic [CW-1:0] cnt;
        int            lat;   // exact latency, or -1 meaning "anywhere in 2..N"
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    bit   rand_ready = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    // Reference: ones packed at the LSB end form a thermometer code of length popcount.
    function automatic exp_t model(logic [N-1:0] d);
        exp_t        e;
        int          c = 0;
        logic [63:0] therm;
        for (int i = 0; i < N; i++) c += int'(d[i]);
        therm = (64'd1 << c) - 64'd1;
        e.data = therm[N-1:0];
        e.cnt  = CW'(c);
`ifdef SORT_EARLY_EXIT_EN
        e.lat  = (d == therm[N-1:0]) ? 2 : -1;
`else
        e.lat  = N;
`endif
        return e;
    endfunction

    task automatic wait_idle();
        int t = 0;
        while (!in_ready && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) check("idle_timeout", 0, 1);
    endtask

    task automatic issue(input logic [N-1:0] d, input bit track);
        wait_idle();
        if (track) sb.push_back(model(d));
        in_valid = 1'b1;
        data_in  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_in  = N'($urandom);
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor
    int            ncyc = 0;
    int            acc_cyc = 0;
    bit            pend = 1'b0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [N-1:0]  prev_data = '0;
    logic [CW-1:0] prev_cnt = '0;

    always @(negedge clk) begin
        exp_t e;
        int   lat;
        ncyc++;
        if (!rst_n) begin
            pend       = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("data_out", 64'(data_out), 64'(e.data));
                    check("count_out", 64'(count_out), 64'(e.cnt));
                    lat = ncyc - acc_cyc - 1;
                    if (!pend) check("no_acceptance_seen", 0, 1);
                    else if (e.lat >= 0) check("latency", 64'(lat), 64'(e.lat));
                    else check("latency_in_range", 64'(lat >= 2 && lat <= N), 1);
                end
                pend = 1'b0;
            end
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 64'(out_valid), 1);
                check("hold_data", 64'(data_out), 64'(prev_data));
                check("hold_count", 64'(count_out), 64'(prev_cnt));
            end
            if (prev_valid && prev_ready) begin
                check("drain_valid", 64'(out_valid), 0);
                check("drain_in_ready", 64'(in_ready), 1);
            end
            if (out_valid) check("in_ready_in_done", 64'(in_ready), 0);
            if (!out_valid) begin
                check("idle_data_zero", 64'(data_out), 0);
                check("idle_count_zero", 64'(count_out), 0);
            end
            if (in_valid && in_ready) begin
                pend    = 1'b1;
                acc_cyc = ncyc;
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = data_out;
            prev_cnt   = count_out;
        end
    end

    initial begin
        int t;
        logic [N-1:0] d;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 0);
        check("reset_data_out", 64'(data_out), 0);
        check("reset_count_out", 64'(count_out), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_in_ready", 64'(in_ready), 1);

        out_ready = 1'b1;
        issue(16'h8000, 1'b1);
        issue(16'hA5A5, 1'b1);
        issue(16'hFFFF, 1'b1);
        issue(16'h0000, 1'b1);

        // Backpressure: hold the result five cycles, then release.
        wait_idle();
        out_ready = 1'b0;
        issue(16'hF0F0, 1'b1);
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("bp_result_seen", 64'(out_valid), 1);
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("bp_in_ready_low", 64'(in_ready), 0);
        check("bp_still_valid", 64'(out_valid), 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 64'(out_valid), 0);
        check("bp_release_data", 64'(data_out), 0);
        check("bp_release_in_ready", 64'(in_ready), 1);

        // Abort mid-sort with reset; the vector must never produce a result.
        issue(16'h0F0F, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_out_valid", 64'(out_valid), 0);
        check("abort_in_ready", 64'(in_ready), 1);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
        end
        check("abort_no_result", 64'(out_valid), 0);
        issue(16'h0003, 1'b1);

        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d = N'($urandom);
            if (i % 4 == 0) d = N'((32'd1 << $urandom_range(0, N)) - 32'd1);
            issue(d, 1'b1);
        end
        rand_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle();
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("scoreboard_empty", 64'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
